addsub_seq_ctrl: RTL

Nibble-serial sequencer that performs WIDTH-bit addition or subtraction by time-multiplexing a single 4-bit add/sub slice over WIDTH/4 cycles. It carries the slice's carry/borrow from nibble to nibble, and it presents operands and results through valid/ready handshakes. It sits between an operand source (register file or bus interface) and any result consumer. It replaces a full-width ripple chain where area matters more than latency.

---
 rtl/addsub_seq_pkg.sv | 15 +
 rtl/addsub_nibble.sv | 26 ++
 rtl/addsub_seq_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the nibble-serial add/sub sequencer.
package addsub_seq_pkg;

  // Controller state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operation select values for the mode input.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_nibble.sv
// Gate-level 4-bit add/sub slice. B is inverted when m=1. The carry-in is a
// separate pin so the controller can chain carry/borrow between nibbles.
module addsub_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       m,
  input  logic       cin,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] bx;
  logic [4:0] c;

  assign bx   = b ^ {4{m}};
  assign c[0] = cin;

  // Ripple of four full adders built from plain gates.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  assign co = c[4];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial WIDTH-bit adder/subtractor built around one addsub_nibble.
// Optional feature: define ADDSUB_SEQ_OVF_EN to add the signed-overflow
// output ovf.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE and
// the result stays stable until the edge where out_ready is sampled high.
// Both decode from the state register alone, never from in_valid/out_ready.
module addsub_seq_ctrl
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
`ifdef ADDSUB_SEQ_OVF_EN
  output logic             ovf,
`endif
  output state_t           dbg_state
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic             mode_r, carry, cout_r;
  logic [IDXW-1:0]  idx;
  logic [3:0]       a_nib, b_nib, s_nib;
  logic             co_nib, last;
`ifdef ADDSUB_SEQ_OVF_EN
  logic             ovf_r;
`endif

  assign last = (idx == IDXW'(NIB - 1));

  // Select the operand nibbles addressed by idx.
  always_comb begin
    a_nib = 4'd0;
    b_nib = 4'd0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IDXW'(i)) begin
        a_nib = a_r[4*i +: 4];
        b_nib = b_r[4*i +: 4];
      end
    end
  end

  addsub_nibble u_nibble (
    .a   (a_nib),
    .b   (b_nib),
    .m   (mode_r),
    .cin (carry),
    .s   (s_nib),
    .co  (co_nib)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, per-nibble result write and carry/index sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      mode_r <= MODE_ADD;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      idx    <= '0;
`ifdef ADDSUB_SEQ_OVF_EN
      ovf_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r    <= a;
            b_r    <= b;
            mode_r <= mode;
            carry  <= mode;
            sum_r  <= '0;
            cout_r <= 1'b0;
            idx    <= '0;
`ifdef ADDSUB_SEQ_OVF_EN
            ovf_r  <= 1'b0;
`endif
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (idx == IDXW'(i)) sum_r[4*i +: 4] <= s_nib;
          end
          carry <= co_nib;
          if (last) begin
            cout_r <= co_nib;
`ifdef ADDSUB_SEQ_OVF_EN
            // The top nibble's s_nib[3] is the result MSB being written now.
            ovf_r  <= (a_r[WIDTH-1] == (b_r[WIDTH-1] ^ mode_r)) &&
                      (s_nib[3] != a_r[WIDTH-1]);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum       = sum_r;
  assign cout      = cout_r;
  assign dbg_state = state;
`ifdef ADDSUB_SEQ_OVF_EN
  assign ovf       = ovf_r;
`endif

endmodule
